// File: rtl/audio_sample_fifo_pkg.sv
// Shared sample types and I2S frame constants for the audio sample FIFO slice.
package audio_pkg;
   localparam int unsigned SAMPLE_W        = 32;
   localparam int unsigned I2S_FRAME_MCLKS = 256;
   typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/audio_sample_fifo_if.sv
// Writer / I2S-transmitter bundle for audio_sample_fifo; slave is the FIFO side.
interface audio_sample_fifo_if import audio_pkg::*; #(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned AW = $clog2(DEPTH);

   sample_t       WR_DATA;
   logic          WR_EN;
   logic          FULL;
   logic          ALMOST_FULL;
   logic          LRCLK;
   logic          FIFO_READ;
   sample_t       AUDIO;
   logic          FIFO_EMPTY;
   logic [AW:0]   LEVEL;
   logic          UNDERRUN;
   logic          OVERFLOW;

   modport master (
      output WR_DATA, WR_EN, LRCLK, FIFO_READ,
      input  FULL, ALMOST_FULL, AUDIO, FIFO_EMPTY, LEVEL, UNDERRUN, OVERFLOW
   );

   modport slave (
      input  WR_DATA, WR_EN, LRCLK, FIFO_READ,
      output FULL, ALMOST_FULL, AUDIO, FIFO_EMPTY, LEVEL, UNDERRUN, OVERFLOW
   );
endinterface

// File: rtl/audio_sample_fifo_core.sv
// Synchronous sample FIFO: storage, wrapping pointers, occupancy and registered status flags.
module sample_fifo_core import audio_pkg::*; #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned AFULL_LEVEL = DEPTH - 4,
   parameter int unsigned AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  sample_t       push_data,
   input  logic          push_req,
   input  logic          pop_req,
   output sample_t       head,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty,
   output logic          almost_full
);
   localparam logic [AW:0] AFULL_LV = (AW+1)'(AFULL_LEVEL);

   sample_t     mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [AW:0] wr_next, rd_next, level_next;
   logic        push, pop;

   // Flags are computed from next-state pointers so they line up with LEVEL.
   always_comb begin
      push       = push_req & ~full;
      pop        = pop_req & ~empty;
      wr_next    = wr_ptr + {{AW{1'b0}}, push};
      rd_next    = rd_ptr + {{AW{1'b0}}, pop};
      level_next = wr_next - rd_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         almost_full <= 1'b0;
      end else begin
         wr_ptr      <= wr_next;
         rd_ptr      <= rd_next;
         level       <= level_next;
         full        <= (wr_next[AW] != rd_next[AW]) &&
                        (wr_next[AW-1:0] == rd_next[AW-1:0]);
         empty       <= (wr_next == rd_next);
         almost_full <= (level_next >= AFULL_LV);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/audio_sample_fifo.sv
// Frame-paced sample buffer ahead of the I2S transmitter; one pop per LRCLK falling edge.
// Build option: AUDIO_UNDERRUN_HOLD_EN keeps the last sample on underrun instead of silence.
module audio_sample_fifo import audio_pkg::*; #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned AFULL_LEVEL = DEPTH - 4
) (
   input  logic               MCLK,
   input  logic               RESET,
   audio_sample_fifo_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic        lr_q;
   logic        strobe;
   logic        pop_req;
   sample_t     head;
   sample_t     audio;
   logic [AW:0] level;
   logic        fifo_full, fifo_empty, almost_full;
   logic        underrun, overflow;

   // lr_q resets low so a high LRCLK right after reset never looks like a fall.
   assign strobe  = lr_q & ~bus.LRCLK;
   assign pop_req = strobe & bus.FIFO_READ;

   sample_fifo_core #(
      .DEPTH       (DEPTH),
      .AFULL_LEVEL (AFULL_LEVEL)
   ) core (
      .clk         (MCLK),
      .rst         (RESET),
      .push_data   (bus.WR_DATA),
      .push_req    (bus.WR_EN),
      .pop_req     (pop_req),
      .head        (head),
      .level       (level),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .almost_full (almost_full)
   );

   always_ff @(posedge MCLK) begin
      if (RESET) begin
         lr_q     <= 1'b0;
         audio    <= '0;
         underrun <= 1'b0;
         overflow <= 1'b0;
      end else begin
         lr_q <= bus.LRCLK;
         if (pop_req) begin
            if (!fifo_empty) begin
               audio <= head;
            end else begin
               underrun <= 1'b1;
`ifdef AUDIO_UNDERRUN_HOLD_EN
               audio    <= audio;
`else
               audio    <= '0;
`endif
            end
         end
         if (bus.WR_EN && fifo_full)
            overflow <= 1'b1;
      end
   end

   assign bus.AUDIO       = audio;
   assign bus.LEVEL       = level;
   assign bus.FULL        = fifo_full;
   assign bus.FIFO_EMPTY  = fifo_empty;
   assign bus.ALMOST_FULL = almost_full;
   assign bus.UNDERRUN    = underrun;
   assign bus.OVERFLOW    = overflow;
endmodule
